axis_ifft_8point_idft: RTL

- AXI-Stream 8-point inverse DFT. It accepts one 512-bit spectrum beat: 8 complex bins, 32-bit signed real and imaginary parts, in the 8-point DFT output format.
- It returns one 64-bit beat of 8 real Q7 time-domain samples: the result is scaled by 1/8, rounded and saturated.
- It sits downstream of the 8-point DFT, closing the FFT→IFFT loop, and returns samples in the DFT's input format.

---
 rtl/axis_ifft_8point_idft.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/axis_ifft_8point_idft.sv
// rtl/axis_ifft_8point_idft.sv - AXI-Stream 8-point inverse DFT, radix-2 pipeline
// One 512-bit spectrum beat in, one 64-bit beat of eight saturated Q7 samples out.
module axis_ifft_8point_idft #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_AXIS_TOUT_WIDTH  = 64,
  parameter int C_SAT_CNT_WIDTH    = 16
) (
  input  logic                          s_axis_aclk,
  input  logic                          s_axis_aresetn,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic [C_SAT_CNT_WIDTH-1:0]    sat_count
);

  localparam logic signed [52:0] K_Q15 = 53'sd23170;

  logic en;
  logic va, vb, vc;
  logic la, lb, lc;

  logic signed [31:0] x_re [8];
  logic signed [31:0] x_im [8];
  logic signed [32:0] a_re_nxt [8];
  logic signed [32:0] a_im_nxt [8];
  logic signed [32:0] a_re [8];
  logic signed [32:0] a_im [8];
  logic signed [33:0] b_re_nxt [8];
  logic signed [33:0] b_im_nxt [8];
  logic signed [33:0] b_re [8];
  logic signed [33:0] b_im [8];
  logic signed [35:0] c_re_nxt [8];
  logic signed [35:0] c_re [8];
  logic signed [35:0] t1;
  logic signed [35:0] t3;
  logic signed [36:0] r;
  logic [C_AXIS_TOUT_WIDTH-1:0] y_nxt;
  logic clip_nxt;
  logic unused_im;

  assign en            = s_axis_aresetn & (~m_axis_tvalid | m_axis_tready);
  assign s_axis_tready = en;

  // Stage A slots: {Ae0, Ae1, Ao0, Ao1, Be0, Be1, Bo0, Bo1}; pair g uses bins rev2(g) and rev2(g)+4
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x_re[k] = s_axis_tdata[64*k+32 +: 32];
      x_im[k] = s_axis_tdata[64*k +: 32];
    end
    for (int g = 0; g < 4; g++) begin
      int i;
      i = ((g & 1) << 1) | (g >> 1);
      a_re_nxt[2*g]   = 33'(x_re[i]) + 33'(x_re[i+4]);
      a_im_nxt[2*g]   = 33'(x_im[i]) + 33'(x_im[i+4]);
      a_re_nxt[2*g+1] = 33'(x_re[i]) - 33'(x_re[i+4]);
      a_im_nxt[2*g+1] = 33'(x_im[i]) - 33'(x_im[i+4]);
    end
  end

  // Stage B slots: {E0..E3, O0..O3}; multiplying by j maps (re, im) to (-im, re)
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      b_re_nxt[4*h]   = 34'(a_re[4*h])   + 34'(a_re[4*h+2]);
      b_im_nxt[4*h]   = 34'(a_im[4*h])   + 34'(a_im[4*h+2]);
      b_re_nxt[4*h+2] = 34'(a_re[4*h])   - 34'(a_re[4*h+2]);
      b_im_nxt[4*h+2] = 34'(a_im[4*h])   - 34'(a_im[4*h+2]);
      b_re_nxt[4*h+1] = 34'(a_re[4*h+1]) - 34'(a_im[4*h+3]);
      b_im_nxt[4*h+1] = 34'(a_im[4*h+1]) + 34'(a_re[4*h+3]);
      b_re_nxt[4*h+3] = 34'(a_re[4*h+1]) + 34'(a_im[4*h+3]);
      b_im_nxt[4*h+3] = 34'(a_im[4*h+1]) - 34'(a_re[4*h+3]);
    end
  end

  // Only real outputs survive, so stage C keeps just the real parts of x0..x7
  always_comb begin
    t1 = 36'((53'(35'(b_re[5]) - 35'(b_im[5])) * K_Q15) >>> 15);
    t3 = 36'((53'(35'sd0 - 35'(b_re[7]) - 35'(b_im[7])) * K_Q15) >>> 15);
    c_re_nxt[0] = 36'(b_re[0]) + 36'(b_re[4]);
    c_re_nxt[4] = 36'(b_re[0]) - 36'(b_re[4]);
    c_re_nxt[2] = 36'(b_re[2]) - 36'(b_im[6]);
    c_re_nxt[6] = 36'(b_re[2]) + 36'(b_im[6]);
    c_re_nxt[1] = 36'(b_re[1]) + t1;
    c_re_nxt[5] = 36'(b_re[1]) - t1;
    c_re_nxt[3] = 36'(b_re[3]) + t3;
    c_re_nxt[7] = 36'(b_re[3]) - t3;
  end

  assign unused_im = ^{b_im[0], b_im[1], b_im[2], b_im[3], b_im[4]};

  always_comb begin
    y_nxt    = '0;
    clip_nxt = 1'b0;
    r        = '0;
    for (int n = 0; n < 8; n++) begin
      r = (37'(c_re[n]) + 37'sd4) >>> 3;
      if (r > 37'sd127) begin
        y_nxt[8*n +: 8] = 8'h7F;
        clip_nxt        = 1'b1;
      end else if (r < -37'sd128) begin
        y_nxt[8*n +: 8] = 8'h80;
        clip_nxt        = 1'b1;
      end else begin
        y_nxt[8*n +: 8] = r[7:0];
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (en) begin
      for (int i = 0; i < 8; i++) begin
        a_re[i] <= a_re_nxt[i];
        a_im[i] <= a_im_nxt[i];
        b_re[i] <= b_re_nxt[i];
        b_im[i] <= b_im_nxt[i];
        c_re[i] <= c_re_nxt[i];
      end
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (!s_axis_aresetn) begin
      va            <= 1'b0;
      vb            <= 1'b0;
      vc            <= 1'b0;
      la            <= 1'b0;
      lb            <= 1'b0;
      lc            <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdata  <= '0;
      sat_count     <= '0;
    end else begin
      if (en) begin
        va            <= s_axis_tvalid;
        la            <= s_axis_tlast;
        vb            <= va;
        lb            <= la;
        vc            <= vb;
        lc            <= lb;
        m_axis_tvalid <= vc;
        m_axis_tlast  <= lc;
        m_axis_tuser  <= clip_nxt;
        m_axis_tdata  <= y_nxt;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tuser && (sat_count != '1)) begin
        sat_count <= sat_count + 1'b1;
      end
    end
  end

endmodule
